sorter9: RTL and testbench

SORTER9 -- requirements
Module: sorter9

---
 rtl/sorter9_pkg.sv | 29 ++
 rtl/sorter9_cmp_swap.sv | 26 ++
 rtl/sorter9.sv | 158 +++++++++++++++
 tb/tb_sorter9.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sorter9_pkg.sv
// Shared constants for the sorter9 3x3 min/median/max block.
// Optional build macro: SORTER9_PIPE_EN (adds a mid-network register, latency 2).
package sorter9_pkg;

  // Default sample width.
  localparam int SORTER9_DW_DEF    = 8;

  // Network latency options.
  localparam int SORTER9_LAT_COMB  = 1;
  localparam int SORTER9_LAT_PIPE  = 2;

  // Window size and odd-even transposition network shape (N stages sort N items).
  localparam int SORTER9_N         = 9;
  localparam int SORTER9_STAGES    = 9;
  // Number of stages ahead of the optional mid-network register.
  localparam int SORTER9_MID_STAGE = 5;

  // Ranks of interest in the ascending sort.
  localparam int SORTER9_IDX_MIN   = 0;
  localparam int SORTER9_IDX_MED   = 4;
  localparam int SORTER9_IDX_MAX   = 8;

`ifdef SORTER9_PIPE_EN
  localparam int SORTER9_LATENCY   = SORTER9_LAT_PIPE;
`else
  localparam int SORTER9_LATENCY   = SORTER9_LAT_COMB;
`endif

endpackage

// File: rtl/sorter9_cmp_swap.sv
// Compare-exchange element: orders two unsigned operands into (lo, hi).
// Equal operands pass through in their original positions.
module cmp_swap
  import sorter9_pkg::*;
#(
  parameter int DATA_WIDTH = SORTER9_DW_DEF
)
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi
);

  // Swap only when strictly out of order so equal values are untouched.
  always_comb begin
    if (a > b) begin
      lo = b;
      hi = a;
    end else begin
      lo = a;
      hi = b;
    end
  end

endmodule

// File: rtl/sorter9.sv
// sorter9: min / median / max of a 3x3 window of unsigned samples.
// A 9-stage odd-even transposition network of cmp_swap elements fully sorts
// the window; ranks 0, 4 and 8 are registered onto min, med and max.
// Build option SORTER9_PIPE_EN registers the network after stage 5, giving a
// latency of 2 cycles instead of 1 with the same 1 window/cycle throughput.
module sorter9
  import sorter9_pkg::*;
#(
  parameter int DATA_WIDTH = SORTER9_DW_DEF
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_1,
  input  logic [DATA_WIDTH-1:0] in_2,
  input  logic [DATA_WIDTH-1:0] in_3,
  input  logic [DATA_WIDTH-1:0] in_4,
  input  logic [DATA_WIDTH-1:0] in_5,
  input  logic [DATA_WIDTH-1:0] in_6,
  input  logic [DATA_WIDTH-1:0] in_7,
  input  logic [DATA_WIDTH-1:0] in_8,
  input  logic [DATA_WIDTH-1:0] in_9,
  output logic [DATA_WIDTH-1:0] min,
  output logic [DATA_WIDTH-1:0] med,
  output logic [DATA_WIDTH-1:0] max,
  output logic                  out_valid
);

  logic [DATA_WIDTH-1:0] win_s    [SORTER9_N];
  logic [DATA_WIDTH-1:0] mid_s    [SORTER9_N];
  logic [DATA_WIDTH-1:0] mid_in_s [SORTER9_N];
  logic [DATA_WIDTH-1:0] srt_s    [SORTER9_N];
  logic                  mid_valid_s;

  logic [DATA_WIDTH-1:0] min_d, min_q;
  logic [DATA_WIDTH-1:0] med_d, med_q;
  logic [DATA_WIDTH-1:0] max_d, max_q;
  logic                  out_valid_d, out_valid_q;

  assign win_s[0] = in_1;
  assign win_s[1] = in_2;
  assign win_s[2] = in_3;
  assign win_s[3] = in_4;
  assign win_s[4] = in_5;
  assign win_s[5] = in_6;
  assign win_s[6] = in_7;
  assign win_s[7] = in_8;
  assign win_s[8] = in_9;

  // Odd-even transposition network: even stages pair (0,1)..(6,7) and pass
  // item 8 through; odd stages pair (1,2)..(7,8) and pass item 0 through.
  for (genvar s = 0; s < SORTER9_STAGES; s++) begin : g_stage
    logic [DATA_WIDTH-1:0] a_s [SORTER9_N];
    logic [DATA_WIDTH-1:0] y_s [SORTER9_N];

    if (s == 0) begin : g_src_win
      assign a_s = win_s;
    end else if (s == SORTER9_MID_STAGE) begin : g_src_mid
      assign a_s = mid_in_s;
    end else begin : g_src_prev
      assign a_s = g_stage[s-1].y_s;
    end

    for (genvar p = 0; p < 4; p++) begin : g_pair
      localparam int LO = (s % 2) + 2 * p;
      cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
        .a  (a_s[LO]),
        .b  (a_s[LO+1]),
        .lo (y_s[LO]),
        .hi (y_s[LO+1])
      );
    end

    if ((s % 2) == 0) begin : g_pass_top
      assign y_s[SORTER9_N-1] = a_s[SORTER9_N-1];
    end else begin : g_pass_bot
      assign y_s[0] = a_s[0];
    end
  end

  assign mid_s = g_stage[SORTER9_MID_STAGE-1].y_s;
  assign srt_s = g_stage[SORTER9_STAGES-1].y_s;

`ifdef SORTER9_PIPE_EN
  logic [DATA_WIDTH-1:0] mid_d [SORTER9_N];
  logic [DATA_WIDTH-1:0] mid_q [SORTER9_N];
  logic                  mid_valid_d, mid_valid_q;

  // Next state of the mid-network register; data only moves with a valid window.
  always_comb begin
    mid_valid_d = in_valid;
    for (int i = 0; i < SORTER9_N; i++) begin
      if (in_valid) begin
        mid_d[i] = mid_s[i];
      end else begin
        mid_d[i] = mid_q[i];
      end
    end
  end

  // Mid-network register; reset flushes any window in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mid_valid_q <= 1'b0;
      for (int i = 0; i < SORTER9_N; i++) begin
        mid_q[i] <= '0;
      end
    end else begin
      mid_valid_q <= mid_valid_d;
      for (int i = 0; i < SORTER9_N; i++) begin
        mid_q[i] <= mid_d[i];
      end
    end
  end

  assign mid_in_s    = mid_q;
  assign mid_valid_s = mid_valid_q;
`else
  assign mid_in_s    = mid_s;
  assign mid_valid_s = in_valid;
`endif

  // Output next state: load the selected ranks on a valid window, else hold.
  always_comb begin
    out_valid_d = mid_valid_s;
    if (mid_valid_s) begin
      min_d = srt_s[SORTER9_IDX_MIN];
      med_d = srt_s[SORTER9_IDX_MED];
      max_d = srt_s[SORTER9_IDX_MAX];
    end else begin
      min_d = min_q;
      med_d = med_q;
      max_d = max_q;
    end
  end

  // Output registers; asynchronous reset clears results and valid at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q       <= '0;
      med_q       <= '0;
      max_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      min_q       <= min_d;
      med_q       <= med_d;
      max_q       <= max_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign min       = min_q;
  assign med       = med_q;
  assign max       = max_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sorter9.sv
// Self-checking bench for sorter9: a queue-based reference model (sort the
// window, delay by the build latency, hold on idle) is compared with the DUT
// every cycle, alongside literal expectations for the directed windows.
module tb_sorter9;
  import sorter9_pkg::*;

  localparam int W   = 8;
  localparam int LAT = SORTER9_LATENCY;

  typedef struct packed {
    logic         v;
    logic [W-1:0] mn;
    logic [W-1:0] md;
    logic [W-1:0] mx;
  } res_t;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_v [9];
  logic [W-1:0] min_o, med_o, max_o;
  logic         out_valid_o;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic cmp_on   = 1'b0;

  res_t pipe_q [$];
  res_t exp_out;
  res_t got_q  [$];

  sorter9 #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_1      (in_v[0]),
    .in_2      (in_v[1]),
    .in_3      (in_v[2]),
    .in_4      (in_v[3]),
    .in_5      (in_v[4]),
    .in_6      (in_v[5]),
    .in_7      (in_v[6]),
    .in_8      (in_v[7]),
    .in_9      (in_v[8]),
    .min       (min_o),
    .med       (med_o),
    .max       (max_o),
    .out_valid (out_valid_o)
  );

  always #5 clk = ~clk;

  // Reference: plain insertion sort, then pick ranks 0, 4, 8.
  function automatic res_t ref_result(input logic [W-1:0] v [9]);
    logic [W-1:0] s [9];
    logic [W-1:0] key;
    int j;
    res_t r;
    for (int i = 0; i < 9; i++) s[i] = v[i];
    for (int i = 1; i < 9; i++) begin
      key = s[i];
      j = i - 1;
      while (j >= 0 && s[j] > key) begin
        s[j+1] = s[j];
        j = j - 1;
      end
      s[j+1] = key;
    end
    r.v  = 1'b1;
    r.mn = s[0];
    r.md = s[4];
    r.mx = s[8];
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Model: results travel through a LAT-deep delay queue; idle keeps last values.
  initial begin : model
    res_t cur;
    res_t emr;
    for (int i = 0; i < LAT - 1; i++) pipe_q.push_back('0);
    exp_out = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pipe_q.delete();
        for (int i = 0; i < LAT - 1; i++) pipe_q.push_back('0);
        exp_out = '0;
      end else begin
        cur = in_valid ? ref_result(in_v) : res_t'(0);
        pipe_q.push_back(cur);
        emr = pipe_q.pop_front();
        exp_out.v = emr.v;
        if (emr.v) begin
          exp_out.mn = emr.mn;
          exp_out.md = emr.md;
          exp_out.mx = emr.mx;
        end
      end
    end
  end

  // Per-cycle compare against the model, and log of every valid DUT result.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (cmp_on && rst_n) begin
        n_checks++;
        if (out_valid_o === exp_out.v && min_o === exp_out.mn &&
            med_o === exp_out.md && max_o === exp_out.mx) begin
          n_pass++;
        end else begin
          $display("FAIL cycle_cmp t=%0t: got v=%0b min=%0d med=%0d max=%0d, expected v=%0b min=%0d med=%0d max=%0d",
                   $time, out_valid_o, min_o, med_o, max_o,
                   exp_out.v, exp_out.mn, exp_out.md, exp_out.mx);
        end
        if (out_valid_o) got_q.push_back({out_valid_o, min_o, med_o, max_o});
      end
    end
  end

  task automatic apply(input logic [W-1:0] v [9]);
    in_v     = v;
    in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_got(input string name, input int idx,
                         input int emn, input int emd, input int emx);
    res_t r;
    r = (idx < got_q.size()) ? got_q[idx] : res_t'(0);
    chk({name, "_min"}, r.mn, emn);
    chk({name, "_med"}, r.md, emd);
    chk({name, "_max"}, r.mx, emx);
  endtask

  initial begin : stim
    logic [W-1:0] v26 [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [W-1:0] v27 [9] = '{8'd10, 8'd30, 8'd20, 8'd50, 8'd44, 8'd100, 8'd70, 8'd250, 8'd8};
    logic [W-1:0] v28 [9] = '{8'd10, 8'd138, 8'd254, 8'd200, 8'd44, 8'd255, 8'd150, 8'd46, 8'd8};
    logic [W-1:0] v29 [9] = '{8'd100, 8'd20, 8'd19, 8'd65, 8'd70, 8'd150, 8'd252, 8'd100, 8'd101};
    logic [W-1:0] rv  [9];
    res_t r;
    int mode;

    for (int i = 0; i < 9; i++) in_v[i] = 8'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    chk("rst_valid", out_valid_o, 0);
    chk("rst_min", min_o, 0);
    chk("rst_med", med_o, 0);
    chk("rst_max", max_o, 0);

    // Pin the reference model to hand-computed results.
    r = ref_result(v27);
    chk("model27_min", r.mn, 8);  chk("model27_med", r.md, 44);  chk("model27_max", r.mx, 250);
    r = ref_result(v29);
    chk("model29_min", r.mn, 19); chk("model29_med", r.md, 100); chk("model29_max", r.mx, 252);

    rst_n  = 1'b1;
    cmp_on = 1'b1;
    @(negedge clk);

    // All-zero window.
    got_q.delete();
    apply(v26);
    idle(LAT + 1);
    chk("zero_count", got_q.size(), 1);
    chk_got("zero", 0, 0, 0, 0);

    // Full-scale unsigned window.
    got_q.delete();
    apply(v28);
    idle(LAT + 1);
    chk("full_count", got_q.size(), 1);
    chk_got("full", 0, 8, 138, 255);

    // Back-to-back windows, then idle holds the last result.
    got_q.delete();
    apply(v27);
    apply(v29);
    idle(LAT + 1);
    chk("b2b_count", got_q.size(), 2);
    chk_got("b2b_first", 0, 8, 44, 250);
    chk_got("b2b_second", 1, 19, 100, 252);
    chk("hold_valid", out_valid_o, 0);
    chk("hold_med", med_o, 100);
    chk("hold_max", max_o, 252);

    // Asynchronous reset between edges with a window in flight.
    got_q.delete();
    in_v     = v28;
    in_valid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid_o, 0);
    chk("arst_min", min_o, 0);
    chk("arst_med", med_o, 0);
    chk("arst_max", max_o, 0);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle(LAT + 2);
    chk("arst_no_stale", got_q.size(), 0);
    chk("arst_med_after", med_o, 0);

    // First window after reset release.
    got_q.delete();
    apply(v29);
    idle(LAT + 1);
    chk("post_rst_count", got_q.size(), 1);
    chk_got("post_rst", 0, 19, 100, 252);

    // Randomized windows: full range, narrow range (many duplicates), extremes.
    for (int c = 0; c < 400; c++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 9; i++) begin
        if (mode == 0)      rv[i] = W'($urandom_range(0, 255));
        else if (mode == 1) rv[i] = W'($urandom_range(0, 3));
        else                rv[i] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'd255;
      end
      in_v     = rv;
      in_valid = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    idle(LAT + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
